alu_seq: RTL and testbench

Parametrised, registered successor to the team's 4-bit combinational ALU.
- Keeps the same 3-bit operation encoding and adds WIDTH-bit operands, result flags and an iterative unsigned multiply.
- Uses a valid/ready handshake on input and output.
- Sits between the operand register file and the writeback stage; accepts at most one operation in flight.

---
 rtl/alu_seq.sv | 188 ++++++++++++++++++
 tb/tb_alu_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshakes.
// It supports the legacy 3-bit ALU opcodes, result flags and an iterative
// shift-add unsigned multiply. It holds at most one operation in flight.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       F,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_hi,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             err
);

  localparam int unsigned SUM_W  = WIDTH + 1;
  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned CNT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    y_q, y_d;
  logic [WIDTH-1:0]    y_hi_q, y_hi_d;
  logic                carry_q, carry_d;
  logic                ovf_q, ovf_d;
  logic                zero_q, zero_d;
  logic                err_q, err_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                accept;
  logic [WIDTH-1:0]    bx;
  logic [SUM_W-1:0]    sum;
  logic [WIDTH-1:0]    alu_y;
  logic                alu_carry;
  logic                alu_ovf;
  logic                alu_err;
  logic [SUM_W-1:0]    mul_sum;
  logic [PROD_W-1:0]   mul_acc_next;
  logic                mul_last;

  // Handshake: idle always accepts; a held result accepts only when it drains.
  assign in_ready = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle ALU datapath on the live operands (used only at accept).
  always_comb begin
    bx        = F[2] ? ~B : B;
    sum       = SUM_W'({1'b0, A}) + SUM_W'({1'b0, bx}) + SUM_W'(F[2]);
    alu_y     = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    if (F[3]) begin
      alu_err = 1'b1;
    end else begin
      case (F[1:0])
        2'b00: alu_y = A & bx;
        2'b01: alu_y = A | bx;
        2'b10: begin
          alu_y     = sum[WIDTH-1:0];
          alu_carry = sum[WIDTH];
          alu_ovf   = (A[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        end
        default: alu_y = F[2] ? WIDTH'(A > B) : WIDTH'(A == B);
      endcase
    end
  end

  // One shift-add multiply step: add into the upper half, then shift right.
  always_comb begin
    mul_sum      = SUM_W'({1'b0, acc_q[PROD_W-1:WIDTH]})
                 + (mplier_q[0] ? SUM_W'({1'b0, mcand_q}) : SUM_W'(0));
    mul_acc_next = {mul_sum, acc_q[WIDTH-1:1]};
    mul_last     = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    y_hi_d   = y_hi_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    err_d    = err_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: ;
      S_MUL: begin
        acc_d    = mul_acc_next;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (mul_last) begin
          state_d = S_HOLD;
          y_d     = mul_acc_next[WIDTH-1:0];
          y_hi_d  = mul_acc_next[PROD_W-1:WIDTH];
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = (mul_acc_next == '0);
          err_d   = 1'b0;
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new operation (from IDLE, or from HOLD while draining) overrides above.
    if (accept) begin
      if (F == OP_MUL) begin
        state_d  = S_MUL;
        mcand_d  = A;
        mplier_d = B;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        state_d = S_HOLD;
        y_d     = alu_y;
        y_hi_d  = '0;
        carry_d = alu_carry;
        ovf_d   = alu_ovf;
        zero_d  = (alu_y == '0);
        err_d   = alu_err;
      end
    end
  end

  // State and datapath registers; reset discards any partial product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      y_q      <= '0;
      y_hi_q   <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      y_hi_q   <= y_hi_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = (state_q == S_HOLD);
  assign Y         = y_q;
  assign Y_hi      = y_hi_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed, self-checking bench for alu_seq (WIDTH=8).
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [3:0] F = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] Y;
  logic [7:0] Y_hi;
  logic       carry;
  logic       ovf;
  logic       zero;
  logic       err;

  // {out_valid, Y_hi, Y, carry, ovf, zero, err}
  logic [20:0] obs;
  assign obs = {out_valid, Y_hi, Y, carry, ovf, zero, err};

  int errors = 0;
  int checks = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .F         (F),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .Y_hi      (Y_hi),
    .carry     (carry),
    .ovf       (ovf),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation from IDLE for one edge, then scramble the inputs.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    A = a; B = b; F = f; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A = ~a; B = ~b; F = 4'b0111;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (obs !== 21'h0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", obs, 21'h0);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== 21'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset got=%h rdy=%b exp=0 rdy=1", obs, in_ready);
    end
  endtask

  task automatic test_add();
    out_ready = 1'b0;
    issue(8'd200, 8'd100, 4'b0010);
    checks++;
    if (obs !== {1'b1, 8'h00, 8'h2C, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_200_100 got=%h exp=%h", obs, {1'b1, 8'h00, 8'h2C, 4'b1000});
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL hold_in_ready got=%b exp=0", in_ready);
    end
    A = 8'd100; B = 8'd100; F = 4'b0010; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL drain_in_ready got=%b exp=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 8'h00, 8'hC8, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_100_100 got=%h exp=%h", obs, {1'b1, 8'h00, 8'hC8, 4'b0100});
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL add_drain out_valid got=%b exp=0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_alu_vectors();
    logic [7:0] va [12];
    logic [7:0] vb [12];
    logic [3:0] vf [12];
    logic [7:0] vy [12];
    logic [2:0] vcoz [12];  // {carry, ovf, zero}
    va   = '{8'h05, 8'h07, 8'h09, 8'h03, 8'h07, 8'h80, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'h09, 8'h7F};
    vb   = '{8'h07, 8'h07, 8'h03, 8'h09, 8'h07, 8'h01, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h03, 8'h01};
    vf   = '{4'h6,  4'h3,  4'h7,  4'h7,  4'h6,  4'h6,  4'h4,  4'h5,  4'h0,  4'h1,  4'h6,  4'h2};
    vy   = '{8'hFE, 8'h01, 8'h01, 8'h00, 8'h00, 8'h7F, 8'hC0, 8'hF3, 8'h30, 8'hFC, 8'h06, 8'h80};
    vcoz = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b101, 3'b110,
             3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b010};
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      issue(va[i], vb[i], vf[i]);
      checks++;
      if (obs !== {1'b1, 8'h00, vy[i], vcoz[i], 1'b0}) begin
        errors++;
        $display("FAIL alu_vec%0d a=%h b=%h f=%b got=%h exp=%h",
                 i, va[i], vb[i], vf[i], obs, {1'b1, 8'h00, vy[i], vcoz[i], 1'b0});
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_mul();
    logic [7:0] ma [4];
    logic [7:0] mb [4];
    logic [7:0] mhi [4];
    logic [7:0] mlo [4];
    logic       mz [4];
    int n;
    ma  = '{8'hFF, 8'h00, 8'h0D, 8'h80};
    mb  = '{8'hFF, 8'h55, 8'h0B, 8'h02};
    mhi = '{8'hFE, 8'h00, 8'h00, 8'h01};
    mlo = '{8'h01, 8'h00, 8'h8F, 8'h00};
    mz  = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      issue(ma[i], mb[i], 4'b1000);
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL mul%0d busy_in_ready cyc=%0d got=%b exp=0", i, n, in_ready);
        end
        tick();
        n++;
      end
      checks++;
      if (n !== 8) begin
        errors++; $display("FAIL mul%0d latency got=%0d exp=8 edges after accept", i, n);
      end
      checks++;
      if (obs !== {1'b1, mhi[i], mlo[i], 1'b0, 1'b0, mz[i], 1'b0}) begin
        errors++;
        $display("FAIL mul%0d result got=%h exp=%h", i, obs,
                 {1'b1, mhi[i], mlo[i], 1'b0, 1'b0, mz[i], 1'b0});
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL mul%0d drain out_valid got=%b exp=0", i, out_valid);
      end
      out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b0;
    issue(8'd10, 8'd20, 4'b0010);
    A = 8'd3; B = 8'd4; F = 4'b0010; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== {1'b1, 8'h00, 8'h1E, 4'b0000} || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure cyc%0d got=%h rdy=%b exp=%h rdy=0",
                 i, obs, in_ready, {1'b1, 8'h00, 8'h1E, 4'b0000});
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (obs !== {1'b1, 8'h00, 8'h07, 4'b0000}) begin
      errors++; $display("FAIL b2b_add got=%h exp=%h", obs, {1'b1, 8'h00, 8'h07, 4'b0000});
    end
    A = 8'd5; B = 8'd6; F = 4'b1011;
    tick();
    checks++;
    if (obs !== {1'b1, 8'h00, 8'h00, 4'b0011}) begin
      errors++; $display("FAIL reserved_op got=%h exp=%h", obs, {1'b1, 8'h00, 8'h00, 4'b0011});
    end
    A = 8'd3; B = 8'd5; F = 4'b1000;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL hold_to_mul got ov=%b rdy=%b exp ov=0 rdy=0", out_valid, in_ready);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 8 || obs !== {1'b1, 8'h00, 8'h0F, 4'b0000}) begin
      errors++; $display("FAIL hold_to_mul_result lat=%0d got=%h exp lat=8 %h",
                         n, obs, {1'b1, 8'h00, 8'h0F, 4'b0000});
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    out_ready = 1'b0;
    issue(8'h80, 8'h80, 4'b0010);
    checks++;
    if (obs !== {1'b1, 8'h00, 8'h00, 4'b1110}) begin
      errors++; $display("FAIL add_80_80 got=%h exp=%h", obs, {1'b1, 8'h00, 8'h00, 4'b1110});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    issue(8'hFF, 8'hFF, 4'b1000);
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 21'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_mul_reset got=%h rdy=%b exp=0 rdy=1", obs, in_ready);
    end
    tick();
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL no_result_after_reset got=%0d valid cycles exp=0", seen);
    end
    out_ready = 1'b0;
    issue(8'd1, 8'd1, 4'b0010);
    checks++;
    if (obs !== {1'b1, 8'h00, 8'h02, 4'b0000}) begin
      errors++; $display("FAIL add_after_reset got=%h exp=%h", obs, {1'b1, 8'h00, 8'h02, 4'b0000});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_vectors();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
